// File: rtl/c2h_frame_ring_ctrl.sv
// C2H write-side ring manager: gives each captured frame one DDR slot,
// issues one DMA write per frame, and advances C2H_WR_NEXT on completion.
//
// Ports:
//   s_axi_aclk, s_axi_areset  clock, synchronous active-high reset
//   frm_valid/frm_len/frm_ready  frame hand-off from the capture datapath
//   cmd_valid/cmd_ready/cmd_addr/cmd_len  write command to the DDR DMA
//   wr_done  DMA completion pulse for the outstanding command
//   C2H_RD_NEXT / C2H_WR_NEXT  host read / FPGA write ring pointers
//   ring_full, ring_empty  registered ring occupancy flags
//   frm_cnt  committed frame count, err_oversize  sticky oversize flag
//   drop_cnt  frames discarded on a full ring (C2H_DROP_ON_FULL_EN only)
//
// Build option: define C2H_DROP_ON_FULL_EN to discard frames offered while
// the ring is full instead of back-pressuring the capture side.
module c2h_frame_ring_ctrl #(
    parameter logic [31:0] BUF_START = 32'h0000_0000,
    parameter logic [31:0] BUF_END   = 32'h1000_0000,
    parameter logic [31:0] FRM_SIZE  = 32'd2048
) (
    input  logic        s_axi_aclk,
    input  logic        s_axi_areset,
    input  logic        frm_valid,
    input  logic [15:0] frm_len,
    output logic        frm_ready,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [31:0] cmd_addr,
    output logic [15:0] cmd_len,
    input  logic        wr_done,
    input  logic [31:0] C2H_RD_NEXT,
    output logic [31:0] C2H_WR_NEXT,
    output logic        ring_full,
    output logic        ring_empty,
    output logic [31:0] frm_cnt,
    output logic        err_oversize
`ifdef C2H_DROP_ON_FULL_EN
    ,
    output logic [31:0] drop_cnt
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_ADV   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] wr_ptr_q, wr_ptr_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] len_q, len_d;
    logic [31:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        full_q, empty_q;

    logic [32:0] sum;
    logic [31:0] nxt;
    logic        full;
    logic        oversize;
    logic [15:0] len_clamped;
    logic        accept;
    logic        do_drop;

    // 33-bit sum so a ring ending near 4 GiB still wraps correctly
    assign sum         = {1'b0, wr_ptr_q} + {1'b0, FRM_SIZE};
    assign nxt         = (sum >= {1'b0, BUF_END}) ? BUF_START : sum[31:0];
    assign full        = (nxt == C2H_RD_NEXT);
    assign oversize    = ({16'd0, frm_len} > FRM_SIZE);
    assign len_clamped = oversize ? FRM_SIZE[15:0] : frm_len;

`ifdef C2H_DROP_ON_FULL_EN
    logic [31:0] drop_q, drop_d;
    assign do_drop = full;
    assign accept  = !s_axi_areset && (state_q == S_IDLE) && frm_valid;
    assign drop_d  = drop_q + {31'd0, accept && do_drop};
`else
    assign do_drop = 1'b0;
    assign accept  = !s_axi_areset && (state_q == S_IDLE) && frm_valid
                     && !full;
`endif

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        addr_d   = addr_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (oversize) begin
                        err_d = 1'b1;
                    end
                    // zero-length and dropped frames are consumed in place
                    if (!do_drop && frm_len != 16'd0) begin
                        addr_d  = wr_ptr_q;
                        len_d   = len_clamped;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wr_done) begin
                    state_d = S_ADV;
                end
            end
            S_ADV: begin
                wr_ptr_d = nxt;
                cnt_d    = cnt_q + 32'd1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= BUF_START;
            addr_q   <= 32'd0;
            len_q    <= 16'd0;
            cnt_q    <= 32'd0;
            err_q    <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            full_q   <= full;
            empty_q  <= (wr_ptr_q == C2H_RD_NEXT);
        end
    end

`ifdef C2H_DROP_ON_FULL_EN
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            drop_q <= 32'd0;
        end else begin
            drop_q <= drop_d;
        end
    end
    assign drop_cnt = drop_q;
`endif

    assign frm_ready    = accept;
    assign cmd_valid    = (state_q == S_ISSUE);
    assign cmd_addr     = addr_q;
    assign cmd_len      = len_q;
    assign C2H_WR_NEXT  = wr_ptr_q;
    assign ring_full    = full_q;
    assign ring_empty   = empty_q;
    assign frm_cnt      = cnt_q;
    assign err_oversize = err_q;

endmodule

// File: tb/tb_c2h_frame_ring_ctrl.sv
// Bench for c2h_frame_ring_ctrl: 4-slot ring, transaction-level model
// checked every cycle, directed scenarios plus randomized frames.
module tb_c2h_frame_ring_ctrl;

    localparam logic [31:0] BS = 32'h0;
    localparam logic [31:0] BE = 32'h2000;
    localparam logic [31:0] FS = 32'h800;
`ifdef C2H_DROP_ON_FULL_EN
    localparam bit DROP_MODE = 1'b1;
`else
    localparam bit DROP_MODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        frm_valid;
    logic [15:0] frm_len;
    logic        frm_ready;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        wr_done;
    logic [31:0] rd;
    logic [31:0] wr_next;
    logic        ring_full;
    logic        ring_empty;
    logic [31:0] frm_cnt;
    logic        err_oversize;
`ifdef C2H_DROP_ON_FULL_EN
    logic [31:0] drop_cnt;
`endif

    always #5 clk = ~clk;

    c2h_frame_ring_ctrl #(
        .BUF_START(BS),
        .BUF_END  (BE),
        .FRM_SIZE (FS)
    ) dut (
        .s_axi_aclk  (clk),
        .s_axi_areset(rst),
        .frm_valid   (frm_valid),
        .frm_len     (frm_len),
        .frm_ready   (frm_ready),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .wr_done     (wr_done),
        .C2H_RD_NEXT (rd),
        .C2H_WR_NEXT (wr_next),
        .ring_full   (ring_full),
        .ring_empty  (ring_empty),
        .frm_cnt     (frm_cnt),
        .err_oversize(err_oversize)
`ifdef C2H_DROP_ON_FULL_EN
        ,
        .drop_cnt    (drop_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] nxt_of(input logic [31:0] p);
        if (p + FS >= BE) return BS;
        return p + FS;
    endfunction

    function automatic logic [31:0] slot(input int unsigned i);
        return BS + FS * (i % 4);
    endfunction

    // Transaction-level model: a frame is in flight from accept to commit,
    // split into command-pending, awaiting-done and commit-due phases.
    bit          m_started = 1'b0;
    logic [31:0] m_wr, m_cnt, m_addr, m_drop;
    logic [15:0] m_len;
    bit          m_err, m_full, m_empty;
    bit          m_busy, m_pend, m_await, m_commit;
    int          m_issued = 0;
    int          hs_cnt = 0;

    initial begin
        bit exp_rdy, full_now, f_n, e_n;
        forever begin
            @(negedge clk);
            if (m_started) begin
                full_now = (nxt_of(m_wr) == rd);
                exp_rdy = !rst && !m_busy && frm_valid
                          && (DROP_MODE || !full_now);
                chk("wr_next", wr_next, m_wr);
                chk("frm_cnt", frm_cnt, m_cnt);
                chk("err_oversize", {31'd0, err_oversize}, {31'd0, m_err});
                chk("ring_full", {31'd0, ring_full}, {31'd0, m_full});
                chk("ring_empty", {31'd0, ring_empty}, {31'd0, m_empty});
                chk("frm_ready", {31'd0, frm_ready}, {31'd0, exp_rdy});
                chk("cmd_valid", {31'd0, cmd_valid}, {31'd0, m_pend});
                if (m_pend) begin
                    chk("cmd_addr", cmd_addr, m_addr);
                    chk("cmd_len", {16'd0, cmd_len}, {16'd0, m_len});
                end
`ifdef C2H_DROP_ON_FULL_EN
                chk("drop_cnt", drop_cnt, m_drop);
`endif
                if (cmd_valid && cmd_ready) hs_cnt++;
            end
            if (rst) begin
                m_wr = BS; m_cnt = 0; m_err = 0; m_drop = 0;
                m_full = 0; m_empty = 1;
                m_busy = 0; m_pend = 0; m_await = 0; m_commit = 0;
                m_started = 1;
            end else if (m_started) begin
                full_now = (nxt_of(m_wr) == rd);
                f_n = full_now;
                e_n = (m_wr == rd);
                if (m_commit) begin
                    m_wr = nxt_of(m_wr);
                    m_cnt = m_cnt + 1;
                    m_commit = 0;
                    m_busy = 0;
                end else if (m_await) begin
                    if (wr_done) begin
                        m_await = 0;
                        m_commit = 1;
                    end
                end else if (m_pend) begin
                    if (cmd_ready) begin
                        m_pend = 0;
                        m_await = 1;
                    end
                end else if (!m_busy && frm_valid) begin
                    if (DROP_MODE && full_now) begin
                        m_drop = m_drop + 1;
                        if (frm_len > FS) m_err = 1;
                    end else if (!full_now) begin
                        if (frm_len > FS) m_err = 1;
                        if (frm_len != 0) begin
                            m_busy = 1;
                            m_pend = 1;
                            m_addr = m_wr;
                            m_len = (frm_len > FS) ? 16'(FS) : frm_len;
                            m_issued++;
                        end
                    end
                end
                m_full = f_n;
                m_empty = e_n;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [31:0] last_addr;
    logic [15:0] last_len;

    // Offer one frame; if a command is expected, stall cmd_ready for rdly
    // cycles and pulse wr_done ddly cycles after the handshake.
    task automatic send_frame(input logic [15:0] len, input int rdly,
                              input int ddly, input bit exp_cmd,
                              input bit jitter);
        int n;
        frm_valid = 1'b1;
        frm_len = len;
        n = 0;
        forever begin
            @(negedge clk);
            if (frm_ready) break;
            n++;
            if (n > 60) begin
                chk("accept_timeout", 32'd0, 32'd1);
                tick(1);
                frm_valid = 1'b0;
                return;
            end
            tick(1);
        end
        tick(1);
        frm_valid = 1'b0;
        if (jitter) rd = slot($urandom);
        if (!exp_cmd) return;
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, cmd_valid}, 32'd1);
            tick(1);
        end
        cmd_ready = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (cmd_valid) break;
            n++;
            if (n > 20) begin
                chk("cmd_timeout", 32'd0, 32'd1);
                tick(1);
                cmd_ready = 1'b0;
                return;
            end
            tick(1);
        end
        last_addr = cmd_addr;
        last_len = cmd_len;
        tick(1);
        cmd_ready = 1'b0;
        tick(ddly);
        wr_done = 1'b1;
        tick(1);
        wr_done = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;
        logic [15:0] l;
        rst = 1'b1; frm_valid = 1'b0; frm_len = 16'd0;
        cmd_ready = 1'b0; wr_done = 1'b0; rd = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_wr", wr_next, 32'h0);
        chk("rst_empty", {31'd0, ring_empty}, 32'd1);
        chk("rst_full", {31'd0, ring_full}, 32'd0);
        chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        chk("rst_cnt", frm_cnt, 32'd0);
        chk("rst_cmd_addr", cmd_addr, 32'd0);
        chk("rst_cmd_len", {16'd0, cmd_len}, 32'd0);
        tick(1);

        send_frame(16'h400, 0, 3, 1, 0);
        tick(2);
        @(negedge clk);
        chk("f1_addr", last_addr, 32'h0);
        chk("f1_len", {16'd0, last_len}, 32'h400);
        chk("f1_wr", wr_next, 32'h800);
        chk("f1_cnt", frm_cnt, 32'd1);
        chk("f1_empty", {31'd0, ring_empty}, 32'd0);
        tick(1);

        send_frame(16'h200, 0, 0, 1, 0);
        send_frame(16'h200, 0, 0, 1, 0);
        tick(2);
        @(negedge clk);
        chk("fill_wr", wr_next, 32'h1800);
        chk("fill_full", {31'd0, ring_full}, 32'd1);
        tick(1);
        frm_valid = 1'b1;
        frm_len = 16'h300;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_ready", {31'd0, frm_ready}, 32'd0);
            tick(1);
        end
        rd = 32'h800;
        send_frame(16'h300, 1, 1, 1, 0);
        tick(2);
        @(negedge clk);
        chk("wrap_addr", last_addr, 32'h1800);
        chk("wrap_wr", wr_next, 32'h0);
        tick(1);

        rd = 32'h1800;
        h0 = hs_cnt;
        send_frame(16'h123, 5, 2, 1, 0);
        tick(2);
        @(negedge clk);
        chk("stall_addr", last_addr, 32'h0);
        chk("stall_len", {16'd0, last_len}, 32'h123);
        chk("stall_hs", hs_cnt - h0, 32'd1);
        chk("stall_wr", wr_next, 32'h800);
        tick(1);

        send_frame(16'h900, 0, 1, 1, 0);
        tick(2);
        @(negedge clk);
        chk("ovr_len", {16'd0, last_len}, 32'h800);
        chk("ovr_addr", last_addr, 32'h800);
        chk("ovr_err", {31'd0, err_oversize}, 32'd1);
        tick(1);

        rd = 32'h0;
        h0 = hs_cnt;
        send_frame(16'h0, 0, 0, 0, 0);
        tick(3);
        @(negedge clk);
        chk("zero_hs", hs_cnt - h0, 32'd0);
        chk("zero_wr", wr_next, 32'h1000);
        chk("zero_err", {31'd0, err_oversize}, 32'd1);
        tick(1);

`ifdef C2H_DROP_ON_FULL_EN
        rd = 32'h1800;
        h0 = hs_cnt;
        send_frame(16'h100, 0, 0, 0, 0);
        send_frame(16'h100, 0, 0, 0, 0);
        tick(2);
        @(negedge clk);
        chk("drop_cnt2", drop_cnt, 32'd2);
        chk("drop_hs", hs_cnt - h0, 32'd0);
        chk("drop_wr", wr_next, 32'h1000);
        tick(1);
        rd = 32'h0;
`endif

        for (int k = 0; k < 40; k++) begin
            tick(2);
            rd = slot($urandom);
            if (rd == nxt_of(m_wr)) rd = m_wr;
            if ($urandom_range(0, 4) == 0) begin
                wr_done = 1'b1;
                tick(1);
                wr_done = 1'b0;
            end
            case ($urandom_range(0, 7))
                0: l = 16'h0;
                1: l = 16'($urandom_range(16'h801, 16'h900));
                default: l = 16'($urandom_range(1, 16'h800));
            endcase
            send_frame(l, $urandom_range(0, 3), $urandom_range(0, 3),
                       l != 16'h0, $urandom_range(0, 1) == 1);
        end

        tick(2);
        rd = m_wr;
        tick(1);
        frm_valid = 1'b1;
        frm_len = 16'h100;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (frm_ready) break;
            tick(1);
        end
        tick(1);
        frm_valid = 1'b0;
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        tick(1);
        rst = 1'b1;
        rd = 32'h0;
        tick(2);
        rst = 1'b0;
        wr_done = 1'b1;
        tick(1);
        wr_done = 1'b0;
        tick(3);
        @(negedge clk);
        chk("rst_wait_wr", wr_next, 32'h0);
        chk("rst_wait_cnt", frm_cnt, 32'd0);
        chk("rst_wait_valid", {31'd0, cmd_valid}, 32'd0);
        chk("rst_wait_empty", {31'd0, ring_empty}, 32'd1);
        chk("hs_total", hs_cnt, m_issued);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
